// File: rtl/pkt_pkg.sv
// Shared definitions for the packetizer/depacketizer pair: flit field layout,
// FSM state encoding and the default ctrl field values.
package pkt_pkg;

    localparam int W0_MSB   = 47;
    localparam int W0_LSB   = 32;
    localparam int W1_MSB   = 31;
    localparam int W1_LSB   = 16;
    localparam int CTRL_MSB = 15;
    localparam int CTRL_LSB = 0;

    localparam logic [15:0] BODY_CTRL_DEF  = 16'hFFFF;
    localparam logic [15:0] TAIL1_CTRL_DEF = 16'hFFF1;
    localparam logic [15:0] TAIL2_CTRL_DEF = 16'hFFF2;
    localparam logic [15:0] PAD_WORD_DEF   = 16'h0000;

    typedef enum logic [1:0] {
        S_W0,
        S_W1,
        S_SEND
    } state_t;

    function automatic logic [47:0] makeFlit(input logic [15:0] w0,
                                             input logic [15:0] w1,
                                             input logic [15:0] ctrl);
        logic [47:0] f;
        f                    = '0;
        f[W0_MSB:W0_LSB]     = w0;
        f[W1_MSB:W1_LSB]     = w1;
        f[CTRL_MSB:CTRL_LSB] = ctrl;
        return f;
    endfunction

endpackage

// File: rtl/packetizer.sv
// Packs 16-bit payload words into 48-bit flits {word0, word1, ctrl} and holds
// each flit until the router side accepts it; counts accepted tail flits.
module packetizer
    import pkt_pkg::*;
#(
    parameter logic [15:0] BODY_CTRL  = BODY_CTRL_DEF,
    parameter logic [15:0] TAIL1_CTRL = TAIL1_CTRL_DEF,
    parameter logic [15:0] TAIL2_CTRL = TAIL2_CTRL_DEF,
    parameter logic [15:0] PAD_WORD   = PAD_WORD_DEF,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    input  logic             data_last,
    output logic             data_ready,
    output logic [47:0]      flitout,
    output logic             flit_valid,
    input  logic             flit_ready,
    output logic [CNT_W-1:0] pkt_count
);

    state_t            r_state;
    logic [15:0]       r_word0;
    logic [47:0]       r_flit;
    logic              r_valid;
    logic [CNT_W-1:0]  r_count;

    state_t            w_nextState;
    logic [15:0]       w_nextWord0;
    logic [47:0]       w_nextFlit;
    logic              w_nextValid;
    logic              w_inXfer;
    logic              w_flitXfer;
    logic              w_isTail;

    assign w_inXfer   = data_valid && data_ready;
    assign w_flitXfer = r_valid && flit_ready;
    assign w_isTail   = (r_flit[CTRL_MSB:CTRL_LSB] != BODY_CTRL);

    assign flitout    = r_flit;
    assign flit_valid = r_valid;
    assign pkt_count  = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_W0;
            r_word0 <= '0;
            r_flit  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_word0 <= w_nextWord0;
            r_flit  <= w_nextFlit;
            r_valid <= w_nextValid;
            if (w_flitXfer && w_isTail) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // In S_SEND a word arriving alongside the outgoing flit is treated as a fresh word0.
    always_comb begin
        w_nextState = r_state;
        w_nextWord0 = r_word0;
        w_nextFlit  = r_flit;
        w_nextValid = r_valid;
        data_ready  = 1'b1;

        case (r_state)
            S_W0: begin
                if (w_inXfer) begin
                    w_nextWord0 = data_in;
                    if (data_last) begin
                        w_nextFlit  = makeFlit(data_in, PAD_WORD, TAIL1_CTRL);
                        w_nextValid = 1'b1;
                        w_nextState = S_SEND;
                    end else begin
                        w_nextState = S_W1;
                    end
                end
            end
            S_W1: begin
                if (w_inXfer) begin
                    w_nextFlit  = makeFlit(r_word0, data_in,
                                           data_last ? TAIL2_CTRL : BODY_CTRL);
                    w_nextValid = 1'b1;
                    w_nextState = S_SEND;
                end
            end
            S_SEND: begin
                data_ready = flit_ready;
                if (w_flitXfer) begin
                    w_nextValid = 1'b0;
                    w_nextState = S_W0;
                    if (w_inXfer) begin
                        w_nextWord0 = data_in;
                        if (data_last) begin
                            w_nextFlit  = makeFlit(data_in, PAD_WORD, TAIL1_CTRL);
                            w_nextValid = 1'b1;
                            w_nextState = S_SEND;
                        end else begin
                            w_nextState = S_W1;
                        end
                    end
                end
            end
            default: begin
                w_nextState = S_W0;
                w_nextValid = 1'b0;
            end
        endcase
    end

endmodule
